lcd_bus_sequencer: RTL and testbench
====================================

Name: lcd_bus_sequencer

Overview:
Sequences HD44780-style LCD bus transactions on behalf of the CPU. It accepts byte writes (data or command) into a small FIFO, polls the LCD busy flag by status reads, and issues each write only after a not-busy status. It sits between the CPU I/O decode and the LCD module's enable/rnw/rs/data pins, so CPU firmware no longer has to poll.

Parameters:
FIFO_DEPTH, 4, request FIFO entries (power of 2, >=2)
SETUP_CYC, 1, clk cycles rs/rnw/data are stable before lcd_en rises
E_CYC, 2, clk cycles lcd_en is held high
GAP_CYC, 1, clk cycles lcd_en is low between transactions (also data hold)
POLL_LIMIT, 255, max status reads per entry (used only with LCD_POLL_TIMEOUT_EN)

Ports:
clk  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  CPU offers a write
req_ready  out  1  FIFO not full; transfer when req_valid && req_ready
req_rs  in  1  0 = command, 1 = data
req_data  in  8  byte to write
lcd_bus  inout  8  LCD data bus; driven only during write phases, else 'z'
lcd_en  out  1  LCD enable strobe
lcd_rnw  out  1  1 = read, 0 = write
lcd_rs  out  1  register select
busy  out  1  FIFO non-empty or transaction in progress
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries queued
timeout_err  out  1  sticky poll-timeout flag (tied 0 without the macro)

Behaviour:
- Reset (async, immediate): FIFO empty, FSM=IDLE, lcd_en=0, lcd_rnw=1, lcd_rs=0, lcd_bus='z', req_ready=1, busy=0, fifo_count=0, timeout_err=0. Reset mid-strobe drops lcd_en the same instant, which is acceptable to the LCD.
- FIFO: write on req_valid&&req_ready; pop only in WR_HOLD exit. Push and pop in the same cycle leave the count unchanged and are legal when full. Pointers wrap modulo FIFO_DEPTH. req_ready=0 when count==FIFO_DEPTH.
- All LCD outputs are registered; one cycle counter cnt is shared by the timed states.
- FSM:
  IDLE: rnw=1, rs=0, en=0. If FIFO non-empty -> P_SETUP.
  P_SETUP: rnw=1, rs=0, SETUP_CYC cycles -> P_EN.
  P_EN: en=1 for E_CYC cycles. Sample lcd_bus[7] in the last en-high cycle, before en falls -> P_GAP.
  P_GAP: en=0 for GAP_CYC cycles. If the sampled bit is 1 -> P_SETUP. If it is 0 -> W_SETUP.
  W_SETUP: rnw=0, rs=head.rs, drive lcd_bus=head.data, SETUP_CYC cycles -> W_EN.
  W_EN: en=1 for E_CYC cycles, data held -> W_HOLD.
  W_HOLD: en=0, data still driven for GAP_CYC cycles. Then pop, release the bus, rnw=1 -> IDLE. If the FIFO is non-empty, the next IDLE cycle proceeds directly to P_SETUP.
- Every write is preceded by at least one status read. The LCD sets busy after each write and clears it only on a status-read falling edge, so a normal write costs exactly two polls: first read 0x80, second 0x00.
- The bus is never driven by this block while lcd_rnw=1. Direction changes only while en=0.
- busy = (state!=IDLE) || (count!=0).

Optional Feature:
LCD_POLL_TIMEOUT_EN
- Defined: an 8-bit poll counter is cleared on entry to the first P_SETUP of each entry. If the sampled busy bit is still 1 after POLL_LIMIT reads, the head entry is popped without being written, timeout_err is set sticky (cleared only by reset), and the FSM goes to IDLE.
- Undefined: polling is unbounded, there is no counter, and timeout_err is tied 0.

Decomposition:
- Shared package lcd_pkg: FSM state enum (IDLE, P_SETUP, P_EN, P_GAP, W_SETUP, W_EN, W_HOLD); a request struct {rs, data[7:0]}; constant LCD_BUSY_BIT=7.
- One sub-module, lcd_req_fifo: a synchronous FIFO parameterised by depth with push/pop/count/full/empty. The FSM stays in the top level.

Test Plan:
- Reset, then single push rs=1 data=0x41 with the LCD model → two status reads (0x80 then 0x00), then one write with rs=1 and bus=0x41 held across the en high pulse. FIFO empties; busy returns to 0 exactly 2*(SETUP+E+GAP)+(SETUP+E+GAP) cycles after leaving IDLE.
- Push 0x01 (rs=0), 0x48, 0x0A back-to-back → LCD emits command, 'H', '\n' in order. Each write is preceded by a 0x00 status read.
- Push 5 entries with FIFO_DEPTH=4 while the LCD is stalled busy → req_ready=0 after the 4th. The 5th is held until the first pop. A push and pop in the same cycle keep count=4.
- Assert reset while lcd_en=1 in W_EN → lcd_en=0 and lcd_bus='z' immediately. FIFO is empty, and no write reaches the LCD after reset release.
- Force the LCD status to 0x80 permanently, with the macro defined and POLL_LIMIT=3 → exactly 3 status reads, the entry is dropped, timeout_err=1, and the next entry then proceeds normally.
- Bus contention check throughout: lcd_bus is never driven by the DUT while lcd_rnw=1, and direction never changes while lcd_en=1.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types for the LCD bus sequencer: FSM state encoding, queued request
// layout and the position of the busy flag in the LCD status byte.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        P_SETUP = 3'd1,
        P_EN    = 3'd2,
        P_GAP   = 3'd3,
        W_SETUP = 3'd4,
        W_EN    = 3'd5,
        W_HOLD  = 3'd6
    } lcd_state_e;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_req_t;

    localparam int LCD_BUSY_BIT = 7;

endpackage

// File: rtl/lcd_req_fifo.sv
// Request FIFO for the LCD sequencer. DEPTH must be a power of two so the
// pointers wrap naturally; push and pop together are accepted even when full.
module lcd_req_fifo
    import lcd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  lcd_req_t               wdata,
    output lcd_req_t               rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ZERO_CNT  = (AW + 1)'(0);

    lcd_req_t        mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;
    logic            do_push_s;
    logic            do_pop_s;

    assign empty     = (count_r == ZERO_CNT);
    assign full      = (count_r == DEPTH_CNT);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign rdata     = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= ZERO_CNT;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{rs: 1'b0, data: 8'h00};
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/lcd_bus_sequencer.sv
// HD44780-style write sequencer: queues CPU writes, polls the busy flag and
// strobes each byte out. Optional bounded polling via LCD_POLL_TIMEOUT_EN.
module lcd_bus_sequencer
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SETUP_CYC  = 1,
    parameter int E_CYC      = 2,
    parameter int GAP_CYC    = 1,
    parameter int POLL_LIMIT = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_rs,
    input  logic [7:0]                  req_data,
    inout  wire  [7:0]                  lcd_bus,
    output logic                        lcd_en,
    output logic                        lcd_rnw,
    output logic                        lcd_rs,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        timeout_err
);

    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
    localparam logic [7:0] E_LAST     = 8'(E_CYC - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
        (POLL_LIMIT < 1) || (POLL_LIMIT > 255)) begin : g_bad_param
        $error("lcd_bus_sequencer: unsupported FIFO_DEPTH or POLL_LIMIT");
    end

    lcd_state_e state_r;
    lcd_state_e state_nxt_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_nxt_s;
    logic       pop_s;
    logic       push_s;
    logic       full_s;
    logic       empty_s;
    lcd_req_t   head_s;
    logic       busy_bit_r;
    logic       poll_done_s;
    logic       write_phase_s;
    logic       en_r;
    logic       rnw_r;
    logic       rs_r;
    logic       drive_r;
    logic [7:0] bus_data_r;

    assign push_s    = req_valid && req_ready;
    assign req_ready = !full_s;
    assign busy      = (state_r != IDLE) || !empty_s;
    assign lcd_en    = en_r;
    assign lcd_rnw   = rnw_r;
    assign lcd_rs    = rs_r;
    assign lcd_bus   = drive_r ? bus_data_r : 8'hzz;

    lcd_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ('{rs: req_rs, data: req_data}),
        .rdata (head_s),
        .count (fifo_count),
        .full  (full_s),
        .empty (empty_s)
    );

    // State and shared phase counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic; each timed state lasts its cycle budget, then cnt restarts.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r + 8'd1;
        pop_s       = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_nxt_s = 8'd0;
                if (!empty_s) state_nxt_s = P_SETUP;
                else          state_nxt_s = IDLE;
            end
            P_SETUP: begin
                if (cnt_r == SETUP_LAST) begin state_nxt_s = P_EN;  cnt_nxt_s = 8'd0; end
                else                     state_nxt_s = P_SETUP;
            end
            P_EN: begin
                if (cnt_r == E_LAST) begin state_nxt_s = P_GAP; cnt_nxt_s = 8'd0; end
                else                 state_nxt_s = P_EN;
            end
            P_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    cnt_nxt_s = 8'd0;
                    if (!busy_bit_r) begin
                        state_nxt_s = W_SETUP;
                    end else if (poll_done_s) begin
                        state_nxt_s = IDLE;
                        pop_s       = 1'b1;
                    end else begin
                        state_nxt_s = P_SETUP;
                    end
                end else begin
                    state_nxt_s = P_GAP;
                end
            end
            W_SETUP: begin
                if (cnt_r == SETUP_LAST) begin state_nxt_s = W_EN; cnt_nxt_s = 8'd0; end
                else                     state_nxt_s = W_SETUP;
            end
            W_EN: begin
                if (cnt_r == E_LAST) begin state_nxt_s = W_HOLD; cnt_nxt_s = 8'd0; end
                else                 state_nxt_s = W_EN;
            end
            W_HOLD: begin
                if (cnt_r == GAP_LAST) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = 8'd0;
                    pop_s       = 1'b1;
                end else begin
                    state_nxt_s = W_HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 8'd0;
            end
        endcase
    end

    // Busy flag is captured on the edge that ends the last enable-high cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                    busy_bit_r <= 1'b1;
        else if ((state_r == P_EN) && (cnt_r == E_LAST)) busy_bit_r <= lcd_bus[LCD_BUSY_BIT];
        else                                          busy_bit_r <= busy_bit_r;
    end

    assign write_phase_s = (state_nxt_s == W_SETUP) || (state_nxt_s == W_EN) ||
                           (state_nxt_s == W_HOLD);

    // Pin registers decoded from the next state so they line up with state_r;
    // drive and rnw share one condition, so direction flips only with en low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_r       <= 1'b0;
            rnw_r      <= 1'b1;
            rs_r       <= 1'b0;
            drive_r    <= 1'b0;
            bus_data_r <= 8'h00;
        end else begin
            en_r       <= (state_nxt_s == P_EN) || (state_nxt_s == W_EN);
            rnw_r      <= !write_phase_s;
            drive_r    <= write_phase_s;
            rs_r       <= write_phase_s ? head_s.rs   : 1'b0;
            bus_data_r <= write_phase_s ? head_s.data : 8'h00;
        end
    end

`ifdef LCD_POLL_TIMEOUT_EN
    localparam logic [7:0] POLL_LAST = 8'(POLL_LIMIT - 1);

    logic [7:0] poll_cnt_r;
    logic       timeout_err_r;

    assign poll_done_s = (poll_cnt_r >= POLL_LAST);
    assign timeout_err = timeout_err_r;

    // Status reads issued for the current head entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            poll_cnt_r <= 8'd0;
        else if ((state_r == IDLE) && (state_nxt_s == P_SETUP))
            poll_cnt_r <= 8'd0;
        else if ((state_r == P_GAP) && (cnt_r == GAP_LAST) && (poll_cnt_r != 8'hFF))
            poll_cnt_r <= poll_cnt_r + 8'd1;
        else
            poll_cnt_r <= poll_cnt_r;
    end

    // Sticky until reset; P_GAP only returns to IDLE when an entry is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                         timeout_err_r <= 1'b0;
        else if ((state_r == P_GAP) && (state_nxt_s == IDLE)) timeout_err_r <= 1'b1;
        else                                               timeout_err_r <= timeout_err_r;
    end
`else
    assign poll_done_s = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Randomized bench for lcd_bus_sequencer with a behavioural HD44780 model and
// an expected-write list; pass +define+LCD_POLL_TIMEOUT_EN to cover polling limits.
module tb_lcd_bus_sequencer;

    localparam int DEPTH = 4;
    localparam int S     = 1;
    localparam int E     = 2;
    localparam int G     = 1;
    localparam int PL    = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_rs;
    logic [7:0] req_data;
    wire  [7:0] lcd_bus;
    logic       lcd_en;
    logic       lcd_rnw;
    logic       lcd_rs;
    logic       busy;
    logic [$clog2(DEPTH):0] fifo_count;
    logic       timeout_err;

    always #5 clk = ~clk;

    lcd_bus_sequencer #(
        .FIFO_DEPTH(DEPTH), .SETUP_CYC(S), .E_CYC(E), .GAP_CYC(G), .POLL_LIMIT(PL)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_rs(req_rs), .req_data(req_data), .lcd_bus(lcd_bus), .lcd_en(lcd_en),
        .lcd_rnw(lcd_rnw), .lcd_rs(lcd_rs), .busy(busy), .fifo_count(fifo_count),
        .timeout_err(timeout_err)
    );

    // Released bus floats high, so any stray DUT drive shows up as a non-0xFF value.
    for (genvar g = 0; g < 8; g++) begin : g_pull
        pullup (lcd_bus[g]);
    end

    // LCD model: busy after every write, cleared by the falling edge of a status read.
    logic lcd_busy_flag = 1'b1;
    logic stuck = 1'b0;
    assign lcd_bus = (lcd_rnw && lcd_en) ? {lcd_busy_flag, 7'h00} : 8'hzz;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] exp_mem [256];
    int         exp_wr = 0;
    int         exp_rd = 0;
    int         reads_total = 0;
    int         writes_total = 0;
    int         drops = 0;
    int         polls = 0;
    logic       last_status = 1'b1;
    logic       relax = 1'b0;
    logic [7:0] bus_at_rise = 8'h00;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge lcd_en) bus_at_rise = lcd_bus;

    // Transaction-level view of what the LCD sees on each enable falling edge.
    always @(negedge lcd_en or posedge reset) begin
        if (reset) begin
            polls  = 0;
            relax  = 1'b1;
            exp_rd = exp_wr;
        end else if (lcd_rnw) begin
            reads_total++;
            polls++;
            last_status = lcd_busy_flag;
            if (stuck) relax = 1'b1;
`ifdef LCD_POLL_TIMEOUT_EN
            if (lcd_busy_flag && (polls == PL)) begin
                check_val("drop_has_entry", exp_rd < exp_wr, 1);
                exp_rd++;
                drops++;
                polls = 0;
            end
`endif
            if (!stuck) lcd_busy_flag = 1'b0;
        end else begin
            check_val("wr_data_held", lcd_bus, bus_at_rise);
            check_val("wr_after_not_busy", last_status, 0);
            if (!relax) check_val("wr_poll_count", polls, 2);
            check_val("wr_expected", exp_rd < exp_wr, 1);
            if (exp_rd < exp_wr) begin
                check_val("wr_rs", lcd_rs, exp_mem[exp_rd][8]);
                check_val("wr_byte", lcd_bus, exp_mem[exp_rd][7:0]);
                exp_rd++;
            end
            writes_total++;
            polls = 0;
            relax = 1'b0;
            lcd_busy_flag = 1'b1;
        end
    end

    logic prev_en = 1'b0;
    logic prev_rnw = 1'b1;

    // Bus ownership and direction rules, every cycle.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (lcd_rnw && !lcd_en) check_val("bus_released", lcd_bus, 8'hFF);
            if (lcd_rnw && lcd_en)  check_val("bus_status_only", lcd_bus, {lcd_busy_flag, 7'h00});
            if (prev_en && lcd_en)  check_val("dir_stable_en_high", lcd_rnw, prev_rnw);
        end
        prev_en  = lcd_en;
        prev_rnw = lcd_rnw;
    end

    task automatic push_req(input logic rs, input logic [7:0] d, output int waited);
        waited    = 0;
        req_rs    = rs;
        req_data  = d;
        req_valid = 1'b1;
        while (!req_ready && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        check_val("push_accepted", waited < 3000, 1);
        @(negedge clk);
        req_valid = 1'b0;
        exp_mem[exp_wr[7:0]] = {rs, d};
        exp_wr++;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, n < 3000, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1);
    end

    initial begin
        int w;
        int n;
        int r0;
        int w0;
        int d0;
        reset = 1'b1; req_valid = 1'b0; req_rs = 1'b0; req_data = 8'h00;
        repeat (3) @(negedge clk);
        check_val("rst_en", lcd_en, 0);
        check_val("rst_rnw", lcd_rnw, 1);
        check_val("rst_rs", lcd_rs, 0);
        check_val("rst_bus_z", lcd_bus, 8'hFF);
        check_val("rst_ready", req_ready, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_count", fifo_count, 0);
        check_val("rst_timeout", timeout_err, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single data write: two polls and one write, 3 phases of S+E+G after IDLE.
        r0 = reads_total; w0 = writes_total;
        push_req(1'b1, 8'h41, w);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check_val("t1_busy_cycles", n, 1 + 3 * (S + E + G));
        check_val("t1_reads", reads_total - r0, 2);
        check_val("t1_writes", writes_total - w0, 1);
        check_val("t1_count", fifo_count, 0);

        // Back-to-back command and data bytes.
        r0 = reads_total; w0 = writes_total;
        push_req(1'b0, 8'h01, w);
        push_req(1'b1, 8'h48, w);
        push_req(1'b1, 8'h0A, w);
        wait_idle("t2_idle");
        check_val("t2_writes", writes_total - w0, 3);
        check_val("t2_reads", reads_total - r0, 6);
        check_val("t2_all_written", exp_wr - exp_rd, 0);

        // Fill the FIFO while the LCD stays busy; the fifth waits for a pop.
        w0 = writes_total;
        stuck = 1'b1;
        for (int i = 0; i < DEPTH; i++) push_req(1'($urandom_range(0, 1)), 8'(8'h10 + i), w);
        check_val("t3_full_count", fifo_count, DEPTH);
        check_val("t3_not_ready", req_ready, 0);
        stuck = 1'b0;
        push_req(1'b1, 8'h14, w);
        check_val("t3_fifth_held", w > 0, 1);
        check_val("t3_refill_count", fifo_count, DEPTH);
        wait_idle("t3_idle");
        check_val("t3_writes", writes_total - w0, DEPTH + 1);
        check_val("t3_all_written", exp_wr - exp_rd, 0);

        // Random bytes with random spacing.
        w0 = writes_total;
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push_req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), w);
        end
        wait_idle("t4_idle");
        check_val("t4_writes", writes_total - w0, 30);
        check_val("t4_all_written", exp_wr - exp_rd, 0);

`ifdef LCD_POLL_TIMEOUT_EN
        // Stuck-busy LCD: exactly PL reads, entry dropped, then normal service.
        r0 = reads_total; w0 = writes_total; d0 = drops;
        stuck = 1'b1;
        push_req(1'b0, 8'h33, w);
        n = 0;
        while (!timeout_err && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_val("t6_timeout_set", timeout_err, 1);
        wait_idle("t6_idle_drop");
        repeat (10) @(negedge clk);
        check_val("t6_reads", reads_total - r0, PL);
        check_val("t6_drops", drops - d0, 1);
        check_val("t6_no_write", writes_total - w0, 0);
        check_val("t6_count", fifo_count, 0);
        stuck = 1'b0;
        push_req(1'b1, 8'h5A, w);
        wait_idle("t6_idle_next");
        check_val("t6_next_written", writes_total - w0, 1);
        check_val("t6_sticky", timeout_err, 1);
`else
        d0 = drops;
        check_val("t6_no_timeout", timeout_err, 0);
        check_val("t6_no_drops", drops - d0, 0);
`endif

        // Reset in the middle of a write strobe.
        push_req(1'b1, 8'hC3, w);
        push_req(1'b1, 8'h3C, w);
        n = 0;
        while (!(lcd_en && !lcd_rnw) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_val("t5_reached_w_en", n < 500, 1);
        w0 = writes_total;
        reset = 1'b1;
        #1;
        check_val("t5_en_drop", lcd_en, 0);
        check_val("t5_bus_released", lcd_bus, 8'hFF);
        check_val("t5_rnw", lcd_rnw, 1);
        check_val("t5_count", fifo_count, 0);
        check_val("t5_busy", busy, 0);
        check_val("t5_ready", req_ready, 1);
        check_val("t5_timeout_clr", timeout_err, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check_val("t5_no_write_after", writes_total - w0, 0);
        check_val("t5_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
